jk_down_counter_reload: RTL and testbench

//   Synchronous loadable down counter built from the team's jkFlipFlop cells.
//   It is the count-down counterpart of the JK up counter.
//   A start value is loaded, then the counter decrements on each enabled clock.
//   At zero it either auto-reloads (periodic timer) or stops with done set (one-shot).

---
 rtl/jk_down_counter_reload.sv | 149 ++++++++++++++
 tb/tb_jk_down_counter_reload.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/jk_down_counter_reload.sv
// jk_down_counter_reload
//   Loadable down counter whose count bits are jkFlipFlop cells.
//   A start value is loaded. The counter then decrements on each enabled clock.
//   At zero it either reloads the captured start value (periodic timer) or
//   stops with done set (one-shot).
//
// Ports
//   clock         in   1      sole clock, rising edge
//   clear         in   1      asynchronous, active-high reset of all state
//   count_enable  in   1      decrement request
//   load          in   1      capture load_value into q and the reload register
//   load_value    in   WIDTH  start/reload value
//   auto_reload   in   1      1 = periodic, 0 = one-shot (sampled at zero)
//   q             out  WIDTH  current count (jkFlipFlop outputs)
//   borrow_out    out  1      combinational: RUN & count_enable & q==0
//   tc_pulse      out  1      registered, one cycle after each zero event
//   done          out  1      registered, high while in DONE
//   state_dbg     out  2      current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: there is no valid/ready pair. load and count_enable are
// level-sampled requests that are acted on at the rising clock edge where they
// are high. load wins over count_enable.

module jkFlipFlop (
  input  logic clock,
  input  logic clear,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b10:   q <= 1'b1;
        2'b01:   q <= 1'b0;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end
endmodule

module jk_down_counter_reload #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             count_enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             borrow_out,
  output logic             tc_pulse,
  output logic             done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] j_vec, k_vec;
  logic [WIDTH-1:0] low_zero;
  logic             q_zero, run_en, zero_event, decrement, do_reload;

  assign q_zero     = (q == '0);
  assign run_en     = (state == RUN) && count_enable;
  assign zero_event = !load && run_en && q_zero;
  assign decrement  = !load && run_en && !q_zero;
  assign do_reload  = zero_event && auto_reload;
  assign borrow_out = run_en && q_zero;
  assign state_dbg  = state;

  // A bit toggles on decrement exactly when every lower bit is zero
  // (it is being borrowed from).
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign low_zero[gi] = 1'b1;
      end else begin : g_upper
        assign low_zero[gi] = ~|q[gi-1:0];
      end

      jkFlipFlop u_ff (
        .clock (clock),
        .clear (clear),
        .j     (j_vec[gi]),
        .k     (k_vec[gi]),
        .q     (q[gi])
      );
    end
  endgenerate

  // JK drive: set/reset to a value for load or reload, toggle for decrement,
  // J=K=0 to hold (which also holds q at 0 in IDLE and DONE).
  always_comb begin
    j_vec = '0;
    k_vec = '0;
    if (load) begin
      j_vec = load_value;
      k_vec = ~load_value;
    end else if (do_reload) begin
      j_vec = reload_reg;
      k_vec = ~reload_reg;
    end else if (decrement) begin
      j_vec = low_zero;
      k_vec = low_zero;
    end
  end

  always_comb begin
    state_next = state;
    if (load) begin
      state_next = RUN;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        RUN:     if (zero_event && !auto_reload) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state      <= IDLE;
      reload_reg <= '0;
      tc_pulse   <= 1'b0;
      done       <= 1'b0;
    end else begin
      state    <= state_next;
      tc_pulse <= zero_event;
      done     <= (state_next == DONE);
      if (load) begin
        reload_reg <= load_value;
      end
    end
  end

endmodule

// File: tb/tb_jk_down_counter_reload.sv
module tb_jk_down_counter_reload;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       count_enable = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = '0;
  logic       auto_reload = 1'b0;
  logic [3:0] q;
  logic       borrow_out, tc_pulse, done;
  logic [1:0] state_dbg;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // clock/reset block
  always #5 clk = ~clk;

  jk_down_counter_reload #(.WIDTH(4)) dut (
    .clock        (clk),
    .clear        (clear),
    .count_enable (count_enable),
    .load         (load),
    .load_value   (load_value),
    .auto_reload  (auto_reload),
    .q            (q),
    .borrow_out   (borrow_out),
    .tc_pulse     (tc_pulse),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  // Behavioural model: plain arithmetic on a running/done pair.
  int m_q = 0;
  int m_reload = 0;
  bit m_running = 0;
  bit m_done = 0;
  bit m_tc = 0;

  always @(posedge clk or posedge clear) begin
    if (clear) begin
      m_q = 0; m_reload = 0; m_running = 0; m_done = 0; m_tc = 0;
    end else begin
      m_tc = 0;
      if (load) begin
        m_q = load_value; m_reload = load_value; m_running = 1; m_done = 0;
      end else if (m_running && count_enable) begin
        if (m_q == 0) begin
          m_tc = 1;
          if (auto_reload) m_q = m_reload;
          else begin m_running = 0; m_done = 1; end
        end else begin
          m_q = m_q - 1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: every cycle, away from the rising edge
  always @(negedge clk) begin
    if (chk_on) begin
      check("model_q", int'(q), m_q);
      check("model_borrow", int'(borrow_out), int'(m_running && count_enable && m_q == 0));
      check("model_tc", int'(tc_pulse), int'(m_tc));
      check("model_done", int'(done), int'(m_done));
    end
  end

  // driver: apply inputs now (posedge+2), then wait one edge
  task automatic step(input bit l, input int v, input bit ce, input bit ar);
    load = l;
    load_value = 4'(v);
    count_enable = ce;
    auto_reload = ar;
    @(posedge clk);
    #2;
  endtask

  int tc_count;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    clear = 1'b0;
    chk_on = 1'b1;

    // 1: clear pulsed between edges, then IDLE ignores count_enable
    step(1, 6, 0, 0);
    step(0, 0, 1, 0);
    check("t1_pre_q", int'(q), 5);
    clear = 1'b1;
    #1;
    check("t1_clear_q", int'(q), 0);
    check("t1_clear_done", int'(done), 0);
    check("t1_clear_tc", int'(tc_pulse), 0);
    #1;
    clear = 1'b0;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("t1_idle_q", int'(q), 0);

    // 2: one-shot from 5
    step(1, 5, 0, 0);
    check("t2_q_load", int'(q), 5);
    for (int i = 4; i >= 0; i--) begin
      step(0, 0, 1, 0);
      check("t2_q_seq", int'(q), i);
    end
    check("t2_tc_before", int'(tc_pulse), 0);
    step(0, 0, 1, 0);
    check("t2_tc", int'(tc_pulse), 1);
    check("t2_done", int'(done), 1);
    check("t2_q_zero", int'(q), 0);
    step(0, 0, 1, 0);
    check("t2_tc_one_cycle", int'(tc_pulse), 0);
    check("t2_done_hold", int'(done), 1);

    // 3: periodic from 3, tc once per 4 enabled edges
    step(1, 3, 0, 1);
    tc_count = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, 1);
      if (tc_pulse) tc_count++;
    end
    check("t3_tc_count", tc_count, 3);
    check("t3_q_wrap", int'(q), 3);

    // 4: load beats count_enable
    step(1, 9, 0, 1);
    step(1, 12, 1, 1);
    check("t4_load_wins", int'(q), 12);

    // 5: load 15, enable every other cycle
    step(1, 15, 0, 0);
    for (int i = 0; i < 32; i++) begin
      step(0, 0, (i % 2) == 1, 0);
      if (i == 9) check("t5_q_after_5_en", int'(q), 10);
    end
    check("t5_done", int'(done), 1);

    // 6: clear mid-count at 7, no reload afterwards
    step(1, 10, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    check("t6_q7", int'(q), 7);
    clear = 1'b1;
    #1;
    check("t6_clear_q", int'(q), 0);
    #1;
    clear = 1'b0;
    tc_count = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 1);
      if (tc_pulse) tc_count++;
    end
    check("t6_q_idle", int'(q), 0);
    check("t6_no_tc", tc_count, 0);
    check("t6_no_borrow", int'(borrow_out), 0);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
